// File: rtl/ibuffer_pkg.sv
// ibuffer_pkg -- shared width constants for the instruction buffer.
//   INSTR_W      : instruction word width (INSTR_RANGE = INSTR_W-1:0)
//   TARGET_W     : predicted-target width
//   PC_W_DEFAULT : default PC width (PC_RANGE = PC_W-1:0)
package ibuffer_pkg;
  localparam int INSTR_W      = 32;
  localparam int TARGET_W     = 32;
  localparam int PC_W_DEFAULT = 48;
endpackage

// File: rtl/ibuffer_if.sv
// ibuffer_if -- IFU-side and IDU-side signals of the instruction buffer.
//   slave  : used by ibuffer (takes IFU offer + read_en, drives ready/head)
//   master : used by the IFU/IDU side (or a testbench)
interface ibuffer_if
  import ibuffer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) ();
  // IFU -> ibuffer
  logic                ifu2ibuffer_instr_valid;
  logic [INSTR_W-1:0]  ifu2ibuffer_instr;
  logic [PC_W-1:0]     ifu2ibuffer_pc;
  logic                ifu2ibuffer_predicttaken;
  logic [TARGET_W-1:0] ifu2ibuffer_predicttarget;
  logic                ibuffer2ifu_instr_ready;
  // IDU <-> ibuffer
  logic                ibuffer_read_en;
  logic                fifo_empty;
  logic                ibuffer_instr_valid;
  logic [INSTR_W-1:0]  ibuffer_inst_out;
  logic [PC_W-1:0]     ibuffer_pc_out;
  logic                ibuffer_predicttaken_out;
  logic [TARGET_W-1:0] ibuffer_predicttarget_out;

  modport slave (
    input  ifu2ibuffer_instr_valid, ifu2ibuffer_instr, ifu2ibuffer_pc,
           ifu2ibuffer_predicttaken, ifu2ibuffer_predicttarget, ibuffer_read_en,
    output ibuffer2ifu_instr_ready, fifo_empty, ibuffer_instr_valid,
           ibuffer_inst_out, ibuffer_pc_out, ibuffer_predicttaken_out,
           ibuffer_predicttarget_out
  );

  modport master (
    output ifu2ibuffer_instr_valid, ifu2ibuffer_instr, ifu2ibuffer_pc,
           ifu2ibuffer_predicttaken, ifu2ibuffer_predicttarget, ibuffer_read_en,
    input  ibuffer2ifu_instr_ready, fifo_empty, ibuffer_instr_valid,
           ibuffer_inst_out, ibuffer_pc_out, ibuffer_predicttaken_out,
           ibuffer_predicttarget_out
  );
endinterface

// File: rtl/sync_fifo_flush.sv
// sync_fifo_flush -- generic synchronous circular FIFO with flush.
//   clock, reset_n : clock and synchronous active-low reset
//   flush          : clears pointers and count at the next edge, ignores push/pop
//   push/wdata     : write one entry (ignored while full)
//   pop            : advance head (ignored while empty)
//   rdata          : head entry, combinational from the read pointer
//   full, empty    : occupancy flags
module sync_fifo_flush #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left uncleared by reset; the count alone says what is live.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/ibuffer.sv
// ibuffer -- instruction buffer between IFU and IDU.
//   clock, reset_n : clock and synchronous active-low reset
//   flush_valid    : pipeline flush; empties the buffer at the next edge
//   bus (slave)    : IFU offer/ready and IDU read_en/head-entry outputs
// Optional macro IBUFFER_BYPASS_EN: when the buffer is empty, an IFU offer is
// presented to the IDU in the same cycle and, if read, never stored.
module ibuffer
  import ibuffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = PC_W_DEFAULT
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      flush_valid,
  ibuffer_if.slave  bus
);
  localparam int ENTRY_W = INSTR_W + PC_W + 1 + TARGET_W;

  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] head_data;
  logic [ENTRY_W-1:0] sel_data;
  logic [ENTRY_W-1:0] out_data;
  logic               full;
  logic               empty;
  logic               ready;
  logic               out_valid;
  logic               push_fire;
  logic               fifo_push;
  logic               fifo_pop;

  assign wdata = {bus.ifu2ibuffer_instr, bus.ifu2ibuffer_pc,
                  bus.ifu2ibuffer_predicttaken, bus.ifu2ibuffer_predicttarget};

  // Full blocks a push even if the IDU pops in the same cycle.
  assign ready     = !full && !flush_valid;
  assign push_fire = bus.ifu2ibuffer_instr_valid && ready;
  assign fifo_pop  = bus.ibuffer_read_en && !empty && !flush_valid;

`ifdef IBUFFER_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = empty && bus.ifu2ibuffer_instr_valid && !flush_valid;
  assign out_valid  = !empty || bypass_hit;
  assign sel_data   = bypass_hit ? wdata : head_data;
  // A bypassed entry that the IDU takes right away is never written.
  assign fifo_push  = push_fire && !(bypass_hit && bus.ibuffer_read_en);
`else
  assign out_valid  = !empty;
  assign sel_data   = head_data;
  assign fifo_push  = push_fire;
`endif

  assign out_data = out_valid ? sel_data : '0;

  sync_fifo_flush #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush_valid),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (wdata),
    .rdata   (head_data),
    .full    (full),
    .empty   (empty)
  );

  assign bus.ibuffer2ifu_instr_ready = ready;
  assign bus.fifo_empty              = empty;
  assign bus.ibuffer_instr_valid     = out_valid;
  assign {bus.ibuffer_inst_out, bus.ibuffer_pc_out,
          bus.ibuffer_predicttaken_out, bus.ibuffer_predicttarget_out} = out_data;
endmodule

// File: doc/ibuffer.md
IBUFFER -- requirements
Module: ibuffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-002 SHALL have parameter PC_W, default 48, PC width.
REQ-003 SHALL have port clock  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port flush_valid  in  1  pipeline flush from intwb.
REQ-006 SHALL have port ifu2ibuffer_instr_valid  in  1  IFU offers one instruction.
REQ-007 SHALL have port ifu2ibuffer_instr  in  32  instruction word.
REQ-008 SHALL have port ifu2ibuffer_pc  in  PC_W  instruction PC.
REQ-009 SHALL have port ifu2ibuffer_predicttaken  in  1  BPU taken prediction.
REQ-010 SHALL have port ifu2ibuffer_predicttarget  in  32  BPU predicted target.
REQ-011 SHALL have port ibuffer2ifu_instr_ready  out  1  buffer can accept.
REQ-012 SHALL have port ibuffer_read_en  in  1  IDU pops head entry.
REQ-013 SHALL have port fifo_empty  out  1  no stored entries.
REQ-014 SHALL have port ibuffer_instr_valid  out  1  head instruction valid.
REQ-015 SHALL have ports ibuffer_inst_out (32), ibuffer_pc_out (PC_W), ibuffer_predicttaken_out (1), ibuffer_predicttarget_out (32), all out, head entry fields.

Function
REQ-016 SHALL store entries {instr, pc, predicttaken, predicttarget} in a circular array with write pointer, read pointer and count of width log2(DEPTH)+1.
REQ-017 SHALL push when ifu2ibuffer_instr_valid && ibuffer2ifu_instr_ready && !flush_valid; entry written at write pointer, write pointer +1 mod DEPTH.
REQ-018 SHALL drive ibuffer2ifu_instr_ready = (count != DEPTH) && !flush_valid; no push while full, even with same-cycle pop.
REQ-019 SHALL pop when ibuffer_read_en && ibuffer_instr_valid && !flush_valid; read pointer +1 mod DEPTH; read_en while not valid ignored.
REQ-020 SHALL update count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-021 SHALL drive fifo_empty = (count == 0) and, without bypass, ibuffer_instr_valid = !fifo_empty.
REQ-022 SHALL present head-entry fields combinationally from read pointer; all data outputs SHALL be 0 when ibuffer_instr_valid is 0.
REQ-023 SHALL preserve order: entries leave in push order; a pushed entry is visible at head no earlier than the next cycle (latency 1) without bypass.
REQ-024 SHALL, on flush_valid, discard same-cycle push and pop and set pointers and count to 0 at the next edge; fifo_empty = 1 the cycle after.
REQ-025 SHALL wrap pointers from DEPTH-1 to 0 without loss or duplication.

Reset
REQ-026 SHALL, on reset_n = 0 at a clock edge, clear pointers and count; after reset: fifo_empty = 1, ibuffer_instr_valid = 0, ibuffer2ifu_instr_ready = 1, data outputs 0.
REQ-027 SHALL, on reset mid-operation, drop all stored entries; entry storage need not be cleared.

Configuration
REQ-028 SHALL support macro IBUFFER_BYPASS_EN.
REQ-029 With IBUFFER_BYPASS_EN: when count == 0 and ifu2ibuffer_instr_valid && !flush_valid, ibuffer_instr_valid = 1 and outputs show IFU inputs same cycle; if ibuffer_read_en also 1, entry is consumed and not written; fifo_empty stays (count == 0).
REQ-030 Without IBUFFER_BYPASS_EN: no combinational path from IFU inputs to IDU-side outputs.

Structure
REQ-031 SHALL take instruction width and PC range constants from the shared defines/package (INSTR_RANGE, PC_RANGE); no new package types.
REQ-032 SHALL place pointer/count/storage in one sub-module, sync_fifo_flush (generic width, DEPTH, flush input); ibuffer wraps it with field packing and bypass mux.

Verification
REQ-033 Reset, then push pc=0x1000 instr=0x00000013 -> next cycle fifo_empty=0, valid=1, ibuffer_pc_out=0x1000, ibuffer_inst_out=0x00000013.
REQ-034 Push 8 entries, no pops -> ready=0 after 8th; 9th offer not accepted; pop 8 -> pcs returned in order, fifo_empty=1.
REQ-035 Fill to 7, then push and pop every cycle for 20 cycles -> count stays 7, pointers wrap, order intact.
REQ-036 Fill 5, assert flush_valid with simultaneous push and read_en -> next cycle fifo_empty=1, valid=0, nothing popped.
REQ-037 read_en=1 while empty -> count stays 0, no pointer movement, outputs 0.
REQ-038 IBUFFER_BYPASS_EN, empty, push pc=0x2000 with read_en=1 -> same-cycle valid=1, ibuffer_pc_out=0x2000; next cycle fifo_empty=1.
